// File: rtl/hazard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared constants, forwarding-stage encoding and helpers for the
//            N-lane hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int REG_W = 5;
  localparam int NREG  = 32;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_stage_e;

  localparam logic [1:0] RESSRC_LOAD = 2'b01;

  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] r);
    reg_onehot    = '0;
    reg_onehot[r] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Per-register busy bits and outstanding-op counter for the shared
//            multi-cycle unit; exports the effective (write-through) busy view.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int MC_DEPTH = 2,
  localparam int CW = $clog2(MC_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_reg,
  input  logic             i_clr_en,
  input  logic [REG_W-1:0] i_clr_reg,
  output logic [NREG-1:0]  o_eff_busy,
  output logic             o_mc_busy
);

  logic [NREG-1:1] r_busy;
  logic [CW-1:0]   r_cnt;
  logic [NREG-1:0] w_set_vec;
  logic [NREG-1:0] w_clr_vec;
  logic            w_dec;
  logic            w_full;

  assign w_set_vec  = i_set_en ? reg_onehot(i_set_reg) : '0;
  assign w_clr_vec  = i_clr_en ? reg_onehot(i_clr_reg) : '0;
  assign o_eff_busy = {r_busy, 1'b0} & ~w_clr_vec;

  // A done with nothing outstanding (e.g. after a mid-flight reset) is dropped.
  assign w_dec     = i_clr_en && (r_cnt != '0);
  assign w_full    = (r_cnt == CW'(MC_DEPTH));
  assign o_mc_busy = w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_vec[NREG-1:1]) | w_set_vec[NREG-1:1];
      if (i_set_en && !w_dec && !w_full) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !i_set_en) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit_nway.sv
// ============================================================================
// Module   : hazard_unit_nway
// Purpose  : N-lane forwarding, load-use / multi-cycle / structural stall and
//            program-order redirect flush control.
// Options  : HAZARD_PERF_EN adds StallCycles / RedirectCount counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit_nway
  import hazard_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int MC_DEPTH = 2,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*REG_W-1:0] Rs1D,
  input  logic [LANES*REG_W-1:0] Rs2D,
  input  logic [LANES-1:0]       McReqD,
  input  logic [LANES*REG_W-1:0] RdD,
  input  logic [LANES*REG_W-1:0] Rs1E,
  input  logic [LANES*REG_W-1:0] Rs2E,
  input  logic [LANES*REG_W-1:0] RdE,
  input  logic [LANES*2-1:0]     ResultSrcE,
  input  logic [LANES*2-1:0]     PCSrcE,
  input  logic [LANES-1:0]       McStartE,
  input  logic [LANES*REG_W-1:0] RdM,
  input  logic [LANES*REG_W-1:0] RdW,
  input  logic [LANES-1:0]       RegWriteM,
  input  logic [LANES-1:0]       RegWriteW,
  input  logic                   McDone,
  input  logic [REG_W-1:0]       McRd,
  output logic [LANES*2-1:0]     FwdStageA,
  output logic [LANES*2-1:0]     FwdStageB,
  output logic [LANES*LW-1:0]    FwdLaneA,
  output logic [LANES*LW-1:0]    FwdLaneB,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushD,
  output logic [LANES-1:0]       FlushE,
  output logic                   McBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]            StallCycles,
  output logic [31:0]            RedirectCount
`endif
);

  logic [NREG-1:0]  w_eff_busy;
  logic             w_redirect;
  logic [LANES-1:0] w_redir_mask;
  logic             w_start_en;
  logic [REG_W-1:0] w_start_rd;
  logic             w_load_use;
  logic             w_mc_raw;
  logic             w_struct;
  logic             w_stall;

  // W hits are scanned first so any M hit overwrites them; later lanes win.
  function automatic logic [LW+1:0] fwd_pick(
    input logic [REG_W-1:0]       rs,
    input logic [LANES*REG_W-1:0] rdm,
    input logic [LANES*REG_W-1:0] rdw,
    input logic [LANES-1:0]       wem,
    input logic [LANES-1:0]       wew
  );
    fwd_stage_e stg;
    logic [LW-1:0] ln;
    stg = FWD_NONE;
    ln  = '0;
    if (rs != '0) begin
      for (int k = 0; k < LANES; k++) begin
        if (wew[k] && (rdw[k*REG_W +: REG_W] == rs)) begin
          stg = FWD_W;
          ln  = LW'(k);
        end
      end
      for (int k = 0; k < LANES; k++) begin
        if (wem[k] && (rdm[k*REG_W +: REG_W] == rs)) begin
          stg = FWD_M;
          ln  = LW'(k);
        end
      end
    end
    return {stg, ln};
  endfunction

  function automatic logic mc_hit(
    input logic [REG_W-1:0] r,
    input logic [NREG-1:0]  eff,
    input logic             sen,
    input logic [REG_W-1:0] srd
  );
    return (r != '0) && (eff[r] || (sen && (r == srd)));
  endfunction

  always_comb begin
    FwdStageA = '0;
    FwdStageB = '0;
    FwdLaneA  = '0;
    FwdLaneB  = '0;
    for (int l = 0; l < LANES; l++) begin
      {FwdStageA[l*2 +: 2], FwdLaneA[l*LW +: LW]} =
        fwd_pick(Rs1E[l*REG_W +: REG_W], RdM, RdW, RegWriteM, RegWriteW);
      {FwdStageB[l*2 +: 2], FwdLaneB[l*LW +: LW]} =
        fwd_pick(Rs2E[l*REG_W +: REG_W], RdM, RdW, RegWriteM, RegWriteW);
    end
  end

  // Lanes younger than the oldest taken redirect are squashed.
  always_comb begin
    w_redirect   = 1'b0;
    w_redir_mask = '0;
    w_start_en   = 1'b0;
    w_start_rd   = '0;
    for (int j = 0; j < LANES; j++) begin
      if (w_redirect) w_redir_mask[j] = 1'b1;
      if (PCSrcE[j*2 +: 2] != 2'b00) w_redirect = 1'b1;
    end
    for (int j = 0; j < LANES; j++) begin
      if (McStartE[j] && !w_redir_mask[j] && !w_start_en) begin
        w_start_en = 1'b1;
        w_start_rd = RdE[j*REG_W +: REG_W];
      end
    end
  end

  always_comb begin
    w_load_use = 1'b0;
    w_mc_raw   = 1'b0;
    for (int e = 0; e < LANES; e++) begin
      if ((ResultSrcE[e*2 +: 2] == RESSRC_LOAD) && (RdE[e*REG_W +: REG_W] != '0)) begin
        for (int d = 0; d < LANES; d++) begin
          if ((RdE[e*REG_W +: REG_W] == Rs1D[d*REG_W +: REG_W]) ||
              (RdE[e*REG_W +: REG_W] == Rs2D[d*REG_W +: REG_W])) begin
            w_load_use = 1'b1;
          end
        end
      end
    end
    for (int d = 0; d < LANES; d++) begin
      if (mc_hit(Rs1D[d*REG_W +: REG_W], w_eff_busy, w_start_en, w_start_rd) ||
          mc_hit(Rs2D[d*REG_W +: REG_W], w_eff_busy, w_start_en, w_start_rd) ||
          mc_hit(RdD[d*REG_W +: REG_W],  w_eff_busy, w_start_en, w_start_rd)) begin
        w_mc_raw = 1'b1;
      end
    end
  end

  assign w_struct = (|McReqD) && McBusy;
  assign w_stall  = !w_redirect && (w_load_use || w_mc_raw || w_struct);
  assign StallF   = w_stall;
  assign StallD   = w_stall;
  assign FlushD   = w_redirect;
  assign FlushE   = w_redirect ? w_redir_mask : {LANES{w_stall}};

  reg_scoreboard #(
    .MC_DEPTH (MC_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_start_en),
    .i_set_reg  (w_start_rd),
    .i_clr_en   (McDone),
    .i_clr_reg  (McRd),
    .o_eff_busy (w_eff_busy),
    .o_mc_busy  (McBusy)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_redirects;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_redirects    <= '0;
    end else begin
      if (w_stall)    r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_redirect) r_redirects    <= r_redirects + 32'd1;
    end
  end

  assign StallCycles   = r_stall_cycles;
  assign RedirectCount = r_redirects;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_nway.sv
// ============================================================================
// Module   : tb_hazard_unit_nway
// Purpose  : Directed + random checking of hazard_unit_nway against a
//            rule-level reference model (HAZARD_PERF_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit_nway;

  localparam int LANES    = 2;
  localparam int MC_DEPTH = 2;
  localparam int LW       = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [LANES*5-1:0]   Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [LANES-1:0]     McReqD, McStartE, RegWriteM, RegWriteW;
  logic [LANES*2-1:0]   ResultSrcE, PCSrcE;
  logic                 McDone;
  logic [4:0]           McRd;
  logic [LANES*2-1:0]   FwdStageA, FwdStageB;
  logic [LANES*LW-1:0]  FwdLaneA, FwdLaneB;
  logic                 StallF, StallD, FlushD, McBusy;
  logic [LANES-1:0]     FlushE;
`ifdef HAZARD_PERF_EN
  logic [31:0]          StallCycles, RedirectCount;
`endif

  hazard_unit_nway #(.LANES(LANES), .MC_DEPTH(MC_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .McReqD(McReqD), .RdD(RdD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .McStartE(McStartE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .McDone(McDone), .McRd(McRd),
    .FwdStageA(FwdStageA), .FwdStageB(FwdStageB),
    .FwdLaneA(FwdLaneA), .FwdLaneB(FwdLaneB),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .McBusy(McBusy)
`ifdef HAZARD_PERF_EN
    , .StallCycles(StallCycles), .RedirectCount(RedirectCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: the register scoreboard as a plain bit array.
  bit m_busy [32];
  int m_cnt;
  int m_stalls;
  int m_redirs;

  // Expected values, recomputed from current inputs and model state.
  logic [LANES*2-1:0]  e_fsA, e_fsB;
  logic [LANES*LW-1:0] e_flA, e_flB;
  logic                e_stall, e_flushD;
  logic [LANES-1:0]    e_flushE;
  int                  e_redir, e_sl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW+1:0] ref_fwd(input logic [4:0] r);
    if (r == 5'd0) return '0;
    for (int k = LANES - 1; k >= 0; k--)
      if (RegWriteM[k] && RdM[k*5 +: 5] == r) return {2'b10, LW'(k)};
    for (int k = LANES - 1; k >= 0; k--)
      if (RegWriteW[k] && RdW[k*5 +: 5] == r) return {2'b01, LW'(k)};
    return '0;
  endfunction

  function automatic bit ref_mc(input logic [4:0] r);
    bit b;
    if (r == 5'd0) return 1'b0;
    b = m_busy[r] && !(McDone && McRd == r);
    if (e_sl >= 0 && RdE[e_sl*5 +: 5] == r) b = 1'b1;
    return b;
  endfunction

  task automatic compute_exp();
    bit lu, mc, st;
    e_redir = LANES;
    for (int j = 0; j < LANES; j++)
      if (PCSrcE[j*2 +: 2] != 2'b00 && e_redir == LANES) e_redir = j;
    e_sl = -1;
    for (int j = 0; j < LANES; j++)
      if (j <= e_redir && McStartE[j] && e_sl < 0) e_sl = j;
    for (int l = 0; l < LANES; l++) begin
      {e_fsA[l*2 +: 2], e_flA[l*LW +: LW]} = ref_fwd(Rs1E[l*5 +: 5]);
      {e_fsB[l*2 +: 2], e_flB[l*LW +: LW]} = ref_fwd(Rs2E[l*5 +: 5]);
    end
    lu = 1'b0;
    mc = 1'b0;
    for (int e = 0; e < LANES; e++)
      for (int d = 0; d < LANES; d++)
        if (ResultSrcE[e*2 +: 2] == 2'b01 && RdE[e*5 +: 5] != 5'd0 &&
            (RdE[e*5 +: 5] == Rs1D[d*5 +: 5] || RdE[e*5 +: 5] == Rs2D[d*5 +: 5])) lu = 1'b1;
    for (int d = 0; d < LANES; d++)
      if (ref_mc(Rs1D[d*5 +: 5]) || ref_mc(Rs2D[d*5 +: 5]) || ref_mc(RdD[d*5 +: 5])) mc = 1'b1;
    st       = (McReqD != '0) && (m_cnt == MC_DEPTH);
    e_flushD = (e_redir < LANES);
    e_stall  = !e_flushD && (lu || mc || st);
    for (int j = 0; j < LANES; j++)
      e_flushE[j] = e_flushD ? (j > e_redir) : e_stall;
  endtask

  task automatic check_outputs(input string tag);
    compute_exp();
    chk({tag, ":FwdStageA"}, FwdStageA, e_fsA);
    chk({tag, ":FwdLaneA"},  FwdLaneA,  e_flA);
    chk({tag, ":FwdStageB"}, FwdStageB, e_fsB);
    chk({tag, ":FwdLaneB"},  FwdLaneB,  e_flB);
    chk({tag, ":StallF"},    StallF,    e_stall);
    chk({tag, ":StallD"},    StallD,    e_stall);
    chk({tag, ":FlushD"},    FlushD,    e_flushD);
    chk({tag, ":FlushE"},    FlushE,    e_flushE);
    chk({tag, ":McBusy"},    McBusy,    (m_cnt == MC_DEPTH));
    chk({tag, ":cnt"},       dut.u_sb.r_cnt, m_cnt);
`ifdef HAZARD_PERF_EN
    chk({tag, ":StallCycles"},   StallCycles,   m_stalls);
    chk({tag, ":RedirectCount"}, RedirectCount, m_redirs);
`endif
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_cnt    = 0;
    m_stalls = 0;
    m_redirs = 0;
  endtask

  task automatic model_update();
    bit done_eff;
    compute_exp();
    done_eff = McDone && (m_cnt > 0);
    if (McDone) m_busy[McRd] = 1'b0;
    if (e_sl >= 0 && RdE[e_sl*5 +: 5] != 5'd0) m_busy[RdE[e_sl*5 +: 5]] = 1'b1;
    if (e_sl >= 0 && !done_eff) m_cnt = (m_cnt < MC_DEPTH) ? m_cnt + 1 : m_cnt;
    else if (done_eff && e_sl < 0) m_cnt = m_cnt - 1;
    if (e_stall)  m_stalls++;
    if (e_flushD) m_redirs++;
  endtask

  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    Rs1D = '0; Rs2D = '0; RdD = '0; McReqD = '0;
    Rs1E = '0; Rs2E = '0; RdE = '0; ResultSrcE = '0; PCSrcE = '0; McStartE = '0;
    RdM = '0; RdW = '0; RegWriteM = '0; RegWriteW = '0;
    McDone = 1'b0; McRd = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset_mcbusy", McBusy, 1'b0);
    rst = 1'b0;

    // Two M writers of x5: the younger lane 1 is selected.
    idle();
    RdM = {5'd5, 5'd5}; RegWriteM = 2'b11;
    Rs1E[4:0] = 5'd5;
    RdW[9:5] = 5'd6; RegWriteW = 2'b10; Rs2E[9:5] = 5'd6;
    #1;
    chk("fwd_m_stage", FwdStageA[1:0], 2'b10);
    chk("fwd_m_lane",  FwdLaneA[0],    1'b1);
    chk("fwd_w_stage", FwdStageB[3:2], 2'b01);
    step("fwd");

    // Load-use on lane 0 load vs lane 1 decode Rs2.
    idle();
    ResultSrcE[1:0] = 2'b01; RdE[4:0] = 5'd7; Rs2D[9:5] = 5'd7;
    #1;
    chk("lu_stallF", StallF, 1'b1);
    chk("lu_stallD", StallD, 1'b1);
    chk("lu_flushE", FlushE, 2'b11);
    step("loaduse");
    ResultSrcE[1:0] = 2'b00;
    #1;
    chk("lu_gone", StallD, 1'b0);
    step("loaduse_gone");

    // Redirect in lane 0 squashes lane 1's start and overrides the stall.
    idle();
    PCSrcE[1:0] = 2'b01;
    McStartE[1] = 1'b1; RdE[9:5] = 5'd9;
    ResultSrcE[1:0] = 2'b01; RdE[4:0] = 5'd7; Rs1D[4:0] = 5'd7;
    #1;
    chk("redir_flushD", FlushD, 1'b1);
    chk("redir_flushE", FlushE, 2'b10);
    chk("redir_nostall", StallD, 1'b0);
    step("redirect");
    idle();
    Rs1D[4:0] = 5'd9;
    #1;
    chk("redir_x9_free", StallD, 1'b0);
    step("redirect_after");

    // Fill the multi-cycle unit, then structural stall and write-through done.
    idle();
    McStartE[0] = 1'b1; RdE[4:0] = 5'd3;
    step("mc_start3");
    RdE[4:0] = 5'd4;
    step("mc_start4");
    idle();
    McReqD[0] = 1'b1;
    #1;
    chk("mc_busy", McBusy, 1'b1);
    chk("mc_struct_stall", StallD, 1'b1);
    step("mc_struct");
    idle();
    McDone = 1'b1; McRd = 5'd3; Rs1D[9:5] = 5'd3;
    #1;
    chk("mc_done_nostall", StallD, 1'b0);
    step("mc_done3");
    chk("mc_cnt_one", dut.u_sb.r_cnt, 1);

    // Start and done of x6 together: set wins, count unchanged.
    idle();
    McStartE[0] = 1'b1; RdE[4:0] = 5'd6; McDone = 1'b1; McRd = 5'd6;
    step("mc_set_clr6");
    idle();
    Rs1D[4:0] = 5'd6;
    #1;
    chk("mc_x6_busy", StallD, 1'b1);
    chk("mc_cnt_still1", dut.u_sb.r_cnt, 1);

    // Asynchronous reset mid-cycle clears everything immediately.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_cnt", dut.u_sb.r_cnt, 0);
    chk("rst_x6_free", StallD, 1'b0);
    chk("rst_mcbusy", McBusy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    McDone = 1'b1; McRd = 5'd6;
    step("late_done");
    idle();
    Rs1D[4:0] = 5'd6;
    #1;
    chk("late_done_cnt", dut.u_sb.r_cnt, 0);
    step("late_done_after");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int l = 0; l < LANES; l++) begin
        Rs1D[l*5 +: 5] = 5'($urandom_range(0, 7));
        Rs2D[l*5 +: 5] = 5'($urandom_range(0, 7));
        RdD[l*5 +: 5]  = 5'($urandom_range(0, 7));
        McReqD[l]      = ($urandom_range(0, 3) == 0);
        Rs1E[l*5 +: 5] = 5'($urandom_range(0, 7));
        Rs2E[l*5 +: 5] = 5'($urandom_range(0, 7));
        RdE[l*5 +: 5]  = 5'($urandom_range(0, 7));
        ResultSrcE[l*2 +: 2] = 2'($urandom_range(0, 3));
        PCSrcE[l*2 +: 2] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        RdM[l*5 +: 5]  = 5'($urandom_range(0, 7));
        RdW[l*5 +: 5]  = 5'($urandom_range(0, 7));
        RegWriteM[l]   = 1'($urandom_range(0, 1));
        RegWriteW[l]   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 2) == 0) McStartE[$urandom_range(0, LANES - 1)] = 1'b1;
      McDone = ($urandom_range(0, 2) == 0);
      McRd   = 5'($urandom_range(0, 7));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_unit_nway.md
# hazard_unit_nway

N-lane hazard controller for the superscalar in-order core. It resolves per-lane operand forwarding across all lanes in Memory and Writeback, detects load-use hazards, and issues branch/jump redirect flushes in program order. It also keeps a per-register scoreboard and an outstanding-op counter for the shared multi-cycle unit (mul/div). It sits beside the pipeline registers and drives their stall/flush enables plus the Execute-stage forwarding muxes.

## Interface
Parameters:
- LANES, 2, issue width; lane 0 is oldest in program order.
- MC_DEPTH, 2, maximum multi-cycle ops in flight (1..7).

Ports. Widths are per lane unless noted; LW = $clog2(LANES), minimum 1.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  LANES×5  Decode source registers.
- McReqD  in  LANES  Decode instruction targets the multi-cycle unit.
- RdD  in  LANES×5  Decode destination register.
- Rs1E, Rs2E, RdE  in  LANES×5  Execute registers.
- ResultSrcE  in  LANES×2  2'b01 means load.
- PCSrcE  in  LANES×2  non-zero means redirect taken.
- McStartE  in  LANES  multi-cycle op leaves Execute this cycle.
- RdM, RdW  in  LANES×5  Memory/Writeback destinations.
- RegWriteM, RegWriteW  in  LANES  destination valid.
- McDone  in  1  multi-cycle result written this cycle.
- McRd  in  5  destination of McDone.
- FwdStageA, FwdStageB  out  LANES×2  00 none, 10 Memory, 01 Writeback.
- FwdLaneA, FwdLaneB  out  LANES×LW  source lane for the forward.
- StallF, StallD  out  1  freeze fetch / decode group.
- FlushD  out  1  bubble the whole decode group.
- FlushE  out  LANES  bubble each Execute lane.
- McBusy  out  1  outstanding count equals MC_DEPTH.

## Operation
- Forwarding applies to each E lane operand with a non-zero register.
  - Memory hits beat Writeback hits.
  - Within a stage, the highest matching lane index (youngest) wins.
  - Register x0 is never forwarded. No hit gives 00 with lane 0.
- Redirect: let i be the lowest lane with PCSrcE≠0.
  - FlushD=1.
  - FlushE[j]=1 for all j>i.
  - McStartE[j] for j>i is ignored by the scoreboard.
- Load-use: any E lane with a load, RdE≠0 and RdE equal to any D lane's Rs1D/Rs2D.
- Multi-cycle RAW/WAW: any D lane whose Rs1D, Rs2D or RdD (non-zero) hits one of:
  - an effective busy bit;
  - the RdE of a valid McStartE.
- Structural: any McReqD while McBusy.
- Stall: if any of the three hazards above holds, StallF=StallD=1 and FlushE=all ones.
- Priority: a redirect overrides stall; stall outputs are 0 in a redirect cycle.
- Effective busy = busy & ~(McDone ? onehot(McRd) : 0). A completing register does not stall, because the register file is write-through.
- Scoreboard state: busy[31:1] plus a counter cnt of width $clog2(MC_DEPTH+1).
  - A valid start sets busy[RdE] (RdE≠0) and increments cnt.
  - McDone clears busy[McRd] and decrements cnt.
  - Set and clear of the same register in one cycle: set wins.
  - Start and done in the same cycle: cnt is unchanged.
  - At most one valid start per cycle is guaranteed upstream.
- Intra-group decode RAW is excluded by issue logic and is not checked here.

## Timing
- All stall, flush and forward outputs are combinational, in the same cycle as their inputs.
- Scoreboard and counter update on the rising clk edge. A new busy bit is visible the cycle after the start; the same-cycle case is covered by the McStartE check.
- Reset values: busy=0, cnt=0, McBusy=0, perf counters 0. With idle inputs, all stall/flush outputs are 0.
- rst asserted mid-operation discards all outstanding state at once. Any later McDone with cnt=0 is ignored: no underflow, busy stays clear.
- A start while cnt=MC_DEPTH is an upstream error. cnt saturates and does not wrap.

## Configuration
- HAZARD_PERF_EN defined:
  - adds outputs StallCycles (32 bits), counting cycles with StallD=1;
  - adds RedirectCount (32 bits), counting redirect cycles;
  - both wrap modulo 2^32 and reset to 0.
- HAZARD_PERF_EN undefined: these ports and counters do not exist.

## Structure
- hazard_pkg holds:
  - constants REG_W=5 and NREG=32;
  - enum fwd_stage_e {FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10};
  - RESSRC_LOAD=2'b01.
- Sub-module reg_scoreboard holds busy, cnt and McBusy.
  - Inputs: set enable/register and clear enable/register.
  - Output: the effective busy vector.
- Forwarding, hazard and flush logic stay in hazard_unit_nway.

## Test plan
- Lane1 M writes x5, lane0 M writes x5, lane0 E Rs1=x5 -> FwdStageA[0]=10, FwdLaneA[0]=1.
- Lane0 E is a load to x7, lane1 D Rs2=x7 -> StallF=StallD=1, FlushE=2'b11. The next cycle, with a non-load in E -> no stall.
- Lane0 PCSrcE=01, lane1 McStartE with RdE=x9, plus a load-use hazard -> FlushD=1, FlushE=2'b10, no stall, busy[9] stays 0.
- MC_DEPTH=2: two starts (x3, x4), then McReqD -> McBusy=1 and stall. McDone x3 -> a reader of x3 does not stall that cycle, and cnt=1.
- Start on x6 and McDone on x6 in the same cycle -> busy[6]=1 afterwards. Assert rst -> busy=0 and cnt=0 immediately.
- With HAZARD_PERF_EN: 3 stall cycles and 1 redirect -> StallCycles=3, RedirectCount=1.
